// File: rtl/factory_test_sequencer.sv
// factory_test_sequencer: power sequencer for the analog factory-test macro's
// two active-low bias enables (1v8, 3v3).
//
// Domains are brought up in the order 1v8 then 3v3. Each step waits SETTLE_CYC
// cycles. The block holds ACTIVE for a latched dwell, or until stop when dwell
// is 0. Power-down runs in the reverse order, with the same settle time per step.
// A domain that was never enabled is never stepped down.
//
// Optional feature: define FTS_WATCHDOG_EN to bound a dwell==0 ACTIVE hold to
// WDOG_CYC cycles. When the bound expires the block forces power-down and sets
// the sticky wdog_trip flag.
module factory_test_sequencer #(
  parameter int SETTLE_CYC = 1000,
  parameter int DWELL_W    = 8,
  parameter int WDOG_CYC   = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               ena_1v8_n,
  output logic               ena_3v3_n,
  output logic               busy,
  output logic               active,
  output logic               done,
  output logic [2:0]         state,
  output logic               wdog_trip
);

  localparam int          CNT_W       = 32;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
`ifdef FTS_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST   = 32'(WDOG_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP_1V8 = 3'd1,
    S_UP_3V3 = 3'd2,
    S_ACTIVE = 3'd3,
    S_DN_3V3 = 3'd4,
    S_DN_1V8 = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wdog_q, wdog_d;
  logic               en1_n_q, en1_n_d;
  logic               en3_n_q, en3_n_d;
  logic               busy_q, busy_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic               abort_s;
  logic               settle_done_s;
  logic               dwell_done_s;
  logic [CNT_W-1:0]   dwell_last_s;
  state_t             dn_first_s;

  assign abort_s       = stop | ~ena;
  assign settle_done_s = (cnt_q == SETTLE_LAST);
  assign dwell_last_s  = CNT_W'(dwell_q) - 32'd1;
  assign dwell_done_s  = (dwell_q != {DWELL_W{1'b0}}) && (cnt_q == dwell_last_s);
  // The first power-down step depends on which domains are enabled right now.
  assign dn_first_s    = en3_n_q ? S_DN_1V8 : S_DN_3V3;

  // Next-state logic, plus the start-time latches and the watchdog flag.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && ena && (mode != 2'b00)) begin
          mode_d  = mode;
          dwell_d = dwell;
          wdog_d  = 1'b0;
          state_d = mode[0] ? S_UP_1V8 : S_UP_3V3;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UP_1V8: begin
        if (abort_s) begin
          state_d = dn_first_s;
        end else if (settle_done_s) begin
          state_d = mode_q[1] ? S_UP_3V3 : S_ACTIVE;
        end else begin
          state_d = S_UP_1V8;
        end
      end
      S_UP_3V3: begin
        if (abort_s) begin
          state_d = dn_first_s;
        end else if (settle_done_s) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_UP_3V3;
        end
      end
      S_ACTIVE: begin
        if (abort_s || dwell_done_s) begin
          state_d = dn_first_s;
        end
`ifdef FTS_WATCHDOG_EN
        else if ((dwell_q == {DWELL_W{1'b0}}) && (cnt_q == WDOG_LAST)) begin
          state_d = dn_first_s;
          wdog_d  = 1'b1;
        end
`endif
        else begin
          state_d = S_ACTIVE;
        end
      end
      S_DN_3V3: begin
        if (settle_done_s) begin
          state_d = mode_q[0] ? S_DN_1V8 : S_IDLE;
        end else begin
          state_d = S_DN_3V3;
        end
      end
      S_DN_1V8: begin
        if (settle_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DN_1V8;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Step counter: restarts at every state entry and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered outputs are decoded from the next state, so the pins move with the state register.
  always_comb begin
    en1_n_d  = en1_n_q;
    en3_n_d  = en3_n_q;
    busy_d   = (state_d != S_IDLE);
    active_d = (state_d == S_ACTIVE);
    done_d   = (state_d == S_IDLE) &&
               ((state_q == S_DN_3V3) || (state_q == S_DN_1V8));
    if (state_d != state_q) begin
      case (state_d)
        S_UP_1V8: en1_n_d = 1'b0;
        S_UP_3V3: en3_n_d = 1'b0;
        S_DN_3V3: en3_n_d = 1'b1;
        S_DN_1V8: en1_n_d = 1'b1;
        S_IDLE: begin
          en1_n_d = 1'b1;
          en3_n_d = 1'b1;
        end
        default: begin
          en1_n_d = en1_n_q;
          en3_n_d = en3_n_q;
        end
      endcase
    end else begin
      en1_n_d = en1_n_q;
      en3_n_d = en3_n_q;
    end
  end

  // State, latches, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      dwell_q  <= {DWELL_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      wdog_q   <= 1'b0;
      en1_n_q  <= 1'b1;
      en3_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      en1_n_q  <= en1_n_d;
      en3_n_q  <= en3_n_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign ena_1v8_n = en1_n_q;
  assign ena_3v3_n = en3_n_q;
  assign busy      = busy_q;
  assign active    = active_q;
  assign done      = done_q;
  assign state     = state_q;
  assign wdog_trip = wdog_q;

endmodule

// File: tb/tb_factory_test_sequencer.sv
// Bench for factory_test_sequencer.
// The reference model is a plan of phases (state, duration) built at start time.
// An abort replaces the remaining plan. Every cycle the DUT outputs are
// compared against the model. Directed scenarios also pin literal values.
module tb_factory_test_sequencer;
  localparam int SETTLE = 4;
  localparam int WDOG   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] dwell = 8'd0;
  logic       ena_1v8_n, ena_3v3_n, busy, active, done, wdog_trip;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  factory_test_sequencer #(.SETTLE_CYC(SETTLE), .DWELL_W(8), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
    .mode(mode), .dwell(dwell), .ena_1v8_n(ena_1v8_n), .ena_3v3_n(ena_3v3_n),
    .busy(busy), .active(active), .done(done), .state(state), .wdog_trip(wdog_trip)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of phases ----------------
  typedef struct {int st; int cnt; bit trip;} phase_t;
  phase_t     plan[$];
  int         m_st = 0;
  int         m_rem = 0;
  bit         m_trip = 1'b0;
  bit         m_done = 1'b0;
  bit         m_wdog = 1'b0;
  logic [1:0] m_mode = 2'd0;

  task automatic push(input int s, input int c, input bit t);
    phase_t p;
    p.st = s; p.cnt = c; p.trip = t;
    plan.push_back(p);
  endtask

  task automatic push_down(input bit en3, input bit en1);
    if (en3) push(4, SETTLE, 1'b0);
    if (en1) push(5, SETTLE, 1'b0);
  endtask

  task automatic load_next();
    phase_t p;
    p = plan.pop_front();
    m_st = p.st; m_rem = p.cnt; m_trip = p.trip;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      plan.delete();
      m_st = 0; m_rem = 0; m_trip = 1'b0; m_done = 1'b0; m_wdog = 1'b0; m_mode = 2'd0;
    end else begin
      m_done = 1'b0;
      if (m_st == 0) begin
        if (start && !stop && ena && mode != 2'd0) begin
          m_mode = mode; m_wdog = 1'b0; plan.delete();
          if (mode[0]) push(1, SETTLE, 1'b0);
          if (mode[1]) push(2, SETTLE, 1'b0);
          if (dwell != 8'd0) push(3, int'(dwell), 1'b0);
          else begin
`ifdef FTS_WATCHDOG_EN
            push(3, WDOG, 1'b1);
`else
            push(3, -1, 1'b0);
`endif
          end
          push_down(mode[1], mode[0]);
          load_next();
        end
      end else if ((stop || !ena) && m_st <= 3) begin
        plan.delete();
        push_down(m_mode[1] && m_st != 1, m_mode[0]);
        load_next();
      end else begin
        if (m_rem > 0) m_rem--;
        if (m_rem == 0) begin
          if (m_trip) m_wdog = 1'b1;
          if (plan.size() == 0) begin
            m_st = 0; m_trip = 1'b0; m_done = 1'b1;
          end else begin
            load_next();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_state", {29'd0, state}, 32'(m_st));
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_st != 0});
    chk("cyc_active", {31'd0, active}, {31'd0, m_st == 3});
    chk("cyc_done", {31'd0, done}, {31'd0, m_done});
    chk("cyc_en1n", {31'd0, ena_1v8_n}, {31'd0, !(m_mode[0] && m_st inside {[1:4]})});
    chk("cyc_en3n", {31'd0, ena_3v3_n}, {31'd0, !(m_mode[1] && m_st inside {[2:3]})});
    chk("cyc_wdog", {31'd0, wdog_trip}, {31'd0, m_wdog});
  end

  // ---------------- directed helpers ----------------
  int          lead, trail, act_cnt, busy_cnt, done_cnt, s5_cnt;
  bit          saw1, saw3;
  logic [31:0] seq;

  task automatic go(input logic [1:0] m, input logic [7:0] d);
    mode = m; dwell = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic watch(input int maxc);
    bit         seen3 = 1'b0;
    bit         fin = 1'b0;
    int         n = 0;
    logic [2:0] last = 3'd0;
    lead = 0; trail = 0; act_cnt = 0; busy_cnt = 0; done_cnt = 0; s5_cnt = 0;
    saw1 = 1'b0; saw3 = 1'b0; seq = 32'd0;
    while (!fin && n < maxc) begin
      if (state != last) begin
        seq = {seq[27:0], 1'b0, state};
        last = state;
      end
      if (!ena_1v8_n) saw1 = 1'b1;
      if (!ena_3v3_n) begin saw3 = 1'b1; seen3 = 1'b1; end
      if (!ena_1v8_n && ena_3v3_n) begin
        if (seen3) trail++; else lead++;
      end
      if (active) act_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (state == 3'd5) s5_cnt++;
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("watch_finished", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_en1n", {31'd0, ena_1v8_n}, 32'd1);
    chk("rst_en3n", {31'd0, ena_3v3_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wdog", {31'd0, wdog_trip}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full sequence, both domains
    go(2'd3, 8'd10);
    watch(100);
    chk("t1_lead", lead, 4);
    chk("t1_active", act_cnt, 10);
    chk("t1_trail", trail, 4);
    chk("t1_done", done_cnt, 1);
    chk("t1_seq", seq, 32'h0012_3450);
    chk("t1_busy", busy_cnt, 26);
    @(negedge clk);
    chk("t1_done_width", {31'd0, done}, 32'd0);

    // 2: 3v3 only
    go(2'd2, 8'd3);
    watch(100);
    chk("t2_saw1", {31'd0, saw1}, 32'd0);
    chk("t2_seq", seq, 32'h0000_2340);
    chk("t2_busy", busy_cnt, 11);
    @(negedge clk);

    // 3: stop in the second UP_1V8 cycle
    go(2'd3, 8'd10);
    fork
      watch(50);
      begin
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
      end
    join
    chk("t3_seq", seq, 32'h0000_0150);
    chk("t3_saw3", {31'd0, saw3}, 32'd0);
    chk("t3_dn1v8", s5_cnt, 4);
    chk("t3_busy", busy_cnt, 6);
    @(negedge clk);

    // 4: ena dropped after 7 ACTIVE cycles
    go(2'd1, 8'd0);
    fork
      watch(60);
      begin
        repeat (10) @(negedge clk);
        ena = 1'b0;
      end
    join
    ena = 1'b1;
    chk("t4_active", act_cnt, 7);
    chk("t4_seq", seq, 32'h0000_1350);
    chk("t4_dn1v8", s5_cnt, 4);
    chk("t4_busy", busy_cnt, 15);
    @(negedge clk);

    // 5: ignored starts
    go(2'd0, 8'd5);
    busy_cnt = 0;
    repeat (5) begin busy_cnt += int'(busy); @(negedge clk); end
    chk("t5_mode0_busy", busy_cnt, 0);
    stop = 1'b1;
    go(2'd3, 8'd5);
    stop = 1'b0;
    busy_cnt = 0;
    repeat (5) begin busy_cnt += int'(busy); @(negedge clk); end
    chk("t5_startstop_busy", busy_cnt, 0);
    chk("t5_state", {29'd0, state}, 32'd0);

    // 6: dwell 0 without stop
`ifdef FTS_WATCHDOG_EN
    go(2'd3, 8'd0);
    watch(200);
    chk("t6_active", act_cnt, 20);
    chk("t6_seq", seq, 32'h0012_3450);
    chk("t6_trip", {31'd0, wdog_trip}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_trip_held", {31'd0, wdog_trip}, 32'd1);
    go(2'd1, 8'd2);
    chk("t6_trip_cleared", {31'd0, wdog_trip}, 32'd0);
    watch(50);
`else
    go(2'd3, 8'd0);
    repeat (107) @(negedge clk);
    chk("t6_active_held", {31'd0, active}, 32'd1);
    chk("t6_state", {29'd0, state}, 32'd3);
    chk("t6_trip", {31'd0, wdog_trip}, 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    watch(50);
`endif
    @(negedge clk);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      ena   = ($urandom_range(0, 59) != 0);
      mode  = 2'($urandom_range(0, 3));
      dwell = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1; ena = 1'b1;
    begin
      int n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      chk("final_idle", {31'd0, busy}, 32'd0);
    end
    stop = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
